// File: rtl/risac_ram_pkg.sv
// Shared types and constants for the burst RAM: FSM state, read latency, burst helper.
// Read latency is 2 when RISAC_RAM_OUTREG_EN is defined, otherwise 1.
package risac_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WBURST = 2'd2
    } state_t;

`ifdef RISAC_RAM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // A burstcount of zero is handled as a single beat.
    function automatic int unsigned burst_beats(input int unsigned bc);
        return (bc == 0) ? 32'd1 : bc;
    endfunction

endpackage

// File: rtl/risac_ram_array.sv
// Single-port byte-enabled storage with a 1-cycle registered read.
module risac_ram_array #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/risac_burst_ram.sv
// Avalon-MM burst slave in front of risac_ram_array with clock enable.
// Define RISAC_RAM_OUTREG_EN to add a second output register (read latency 2).
module risac_burst_ram
    import risac_ram_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    BURST_W   = 4,
    parameter string INIT_FILE = "",
    parameter int    ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic                  clken,
    input  logic [BURST_W-1:0]    burstcount,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest
);
    state_t              state_q, state_d;
    logic [BURST_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, mem_addr;
    logic                wr_en, rd_en;
    logic [RD_LAT:1]     vld_pipe_q;
    logic [DATA_W-1:0]   arr_rdata, rdata_src;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    // Everything below only advances on clken; the first beat uses the port address.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        mem_addr = addr_q;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        if (clken && !reset) begin
            unique case (state_q)
                IDLE: begin
                    if (chipselect && (write || read)) begin
                        mem_addr = address;
                        addr_d   = addr_inc(address);
                        cnt_d    = BURST_W'(burst_beats(32'(burstcount)) - 32'd1);
                        wr_en    = write;
                        rd_en    = !write;
                        if (cnt_d != '0) state_d = write ? WBURST : RBURST;
                    end
                end
                RBURST: begin
                    rd_en  = 1'b1;
                    addr_d = addr_inc(addr_q);
                    cnt_d  = cnt_q - BURST_W'(1);
                    if (cnt_q <= BURST_W'(1)) state_d = IDLE;
                end
                WBURST: begin
                    // Cycles with write low are stalls.
                    if (write) begin
                        wr_en  = 1'b1;
                        addr_d = addr_inc(addr_q);
                        cnt_d  = cnt_q - BURST_W'(1);
                        if (cnt_q <= BURST_W'(1)) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            vld_pipe_q <= '0;
        end else if (clken) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            vld_pipe_q <= RD_LAT'({vld_pipe_q, rd_en});
        end
    end

    risac_ram_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en),
        .re_i    (rd_en),
        .addr_i  (mem_addr),
        .be_i    (byteenable),
        .wdata_i (writedata),
        .rdata_o (arr_rdata)
    );

`ifdef RISAC_RAM_OUTREG_EN
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (reset)      out_q <= '0;
        else if (clken) out_q <= arr_rdata;
    end

    assign rdata_src = out_q;
`else
    assign rdata_src = arr_rdata;
`endif

    // A pending word is held, not dropped, while clken is low.
    assign readdata      = reset ? '0 : rdata_src;
    assign readdatavalid = vld_pipe_q[RD_LAT] & clken & ~reset;
    assign waitrequest   = reset | (state_q == RBURST) | ((state_q == IDLE) & ~clken);

endmodule

// File: tb/tb_risac_burst_ram.sv
// Directed self-checking bench for risac_burst_ram (default parameters).
module tb_risac_burst_ram;
`ifdef RISAC_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect, read, write, clken;
    logic [3:0]  burstcount;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_w [0:15];

    always #5 clk = ~clk;

    risac_burst_ram dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .clken         (clken),
        .burstcount    (burstcount),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        burstcount = 4'd1;
        address    = '0;
    endtask

    // Write n beats from exp_w; a stall of stall_len cycles precedes beat stall_at.
    task automatic wr_burst(input int a, input int bc, input int n, input logic [3:0] be,
                            input int stall_at, input int stall_len, input string tag);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = 10'(a); burstcount = 4'(bc); byteenable = be; writedata = exp_w[0];
        chk({tag, "_wr_idle"}, waitrequest, 1'b0);
        tick();
        for (int k = 1; k < n; k++) begin
            if (k == stall_at) begin
                write = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    chk({tag, "_wr_stall"}, waitrequest, 1'b0);
                    tick();
                end
            end
            write = 1'b1; address = 10'd7; writedata = exp_w[k];
            chk({tag, "_wr_beat"}, waitrequest, 1'b0);
            tick();
        end
        idle_bus();
    endtask

    // Read burst; clken is held low for fl cycles after sample fs. Expects exp_w[0..n-1].
    task automatic rd_burst(input int a, input int bc, input int n, input int fs, input int fl,
                            input string tag);
        int got, wcnt, first;
        got = 0; wcnt = 0; first = -1;
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        address = 10'(a); burstcount = 4'(bc);
        tick();
        idle_bus();
        for (int c = 0; c < n + fl + LAT + 4; c++) begin
            if (waitrequest) wcnt++;
            if (readdatavalid) begin
                if (first < 0) first = c;
                if (got < n) chk({tag, "_data"}, readdata, exp_w[got]);
                got++;
            end
            clken = !(c >= fs && c < fs + fl);
            tick();
        end
        clken = 1'b1;
        chk({tag, "_count"}, got, n);
        chk({tag, "_wait_cycles"}, wcnt, n - 1 + fl);
        if (fl == 0) chk({tag, "_latency"}, first, LAT - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset = 1'b1; clken = 1'b1; byteenable = 4'hF; writedata = '0;
        idle_bus();
        repeat (3) tick();
        chk("rst_rdv", readdatavalid, 1'b0);
        chk("rst_rdata", readdata, 32'h0);
        chk("rst_wait", waitrequest, 1'b1);
        reset = 1'b0; #1;
        chk("idle_wait", waitrequest, 1'b0);
        clken = 1'b0; #1;
        chk("idle_wait_noclken", waitrequest, 1'b1);
        clken = 1'b1; #1;

        // Single write / read
        exp_w[0] = 32'hDEADBEEF;
        wr_burst(5, 1, 1, 4'hF, -1, 0, "single");
        rd_burst(5, 1, 1, 0, 0, "single");
        rd_burst(5, 0, 1, 0, 0, "bc_zero");

        // Byte enables
        exp_w[0] = 32'h11223344;
        wr_burst(9, 1, 1, 4'hF, -1, 0, "be_a");
        exp_w[0] = 32'hAABBCCDD;
        wr_burst(9, 1, 1, 4'h5, -1, 0, "be_b");
        exp_w[0] = 32'h11BB33DD;
        rd_burst(9, 1, 1, 0, 0, "be");

        // Address wrap in both directions
        exp_w[0] = 32'h1000_03FE; exp_w[1] = 32'h1000_03FF;
        exp_w[2] = 32'h2000_0000; exp_w[3] = 32'h2000_0001;
        wr_burst(1022, 4, 4, 4'hF, -1, 0, "wrap");
        rd_burst(1022, 4, 4, 0, 0, "wrap");

        // Write burst of 8 with a 2-cycle stall, then read it straight back
        for (int k = 0; k < 8; k++) exp_w[k] = 32'hB000_0000 + 32'(k);
        wr_burst(100, 8, 8, 4'hF, 4, 2, "wstall");
        rd_burst(100, 8, 8, 0, 0, "wstall");

        // Clock-enable freeze in the middle of a read burst
        rd_burst(100, 8, 8, 1, 3, "freeze");

        // Read and write together: write wins, no read data returned
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = 10'd20; burstcount = 4'd1; byteenable = 4'hF; writedata = 32'h5A5A_0014;
        tick();
        idle_bus();
        seen = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            seen = seen | readdatavalid;
            tick();
        end
        chk("rw_no_rdv", seen, 1'b0);
        exp_w[0] = 32'h5A5A_0014;
        rd_burst(20, 1, 1, 0, 0, "rw_write_won");

        // Reset on the 2nd beat of a read burst of 8
        chipselect = 1'b1; read = 1'b1; address = 10'd100; burstcount = 4'd8;
        tick();
        idle_bus();
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("rst_abort_rdv", readdatavalid, 1'b0);
        chk("rst_abort_idle", waitrequest, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            seen = seen | readdatavalid;
            tick();
        end
        chk("rst_abort_no_words", seen, 1'b0);
        exp_w[0] = 32'hB000_0004;
        rd_burst(104, 1, 1, 0, 0, "post_rst");
        exp_w[0] = 32'hDEADBEEF;
        rd_burst(5, 1, 1, 0, 0, "retained");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
